// File: rtl/psg_write_decoder_pkg.sv
// Shared definitions for the SN76489 PSG write decoder.
//
// Contents:
//   reg_type_e     - register type bit carried in the latch (tone/noise vs attenuation)
//   NOISE_CHANNEL  - channel number that selects the noise register when the type is tone
//   ATTEN_RESET    - attenuation reset value (fully silent)
//   busy_state_e   - state encoding of the write busy timer FSM
package psg_write_decoder_pkg;

  typedef enum logic {
    REG_TONE  = 1'b0,
    REG_ATTEN = 1'b1
  } reg_type_e;

  localparam logic [1:0] NOISE_CHANNEL = 2'd3;
  localparam logic [3:0] ATTEN_RESET   = 4'hF;

  typedef enum logic {
    BUSY_IDLE   = 1'b0,
    BUSY_ACTIVE = 1'b1
  } busy_state_e;

endpackage

// File: rtl/psg_write_decoder_busy_timer.sv
// write_busy_timer: holds READY low for WRITE_CYCLES cycles after a write.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   start  in   one-cycle pulse: an accepted write is being applied this cycle
//   ready  out  high while idle (r_state == BUSY_IDLE)
//
// The FSM state is kept in r_state (busy_state_e) so it can be observed directly.
module write_busy_timer
  import psg_write_decoder_pkg::*;
#(
  parameter int WRITE_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic ready
);

  localparam int CNT_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(WRITE_CYCLES - 1);

  busy_state_e      r_state;
  busy_state_e      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= BUSY_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // BUSY spans counts LOAD..0 inclusive, i.e. exactly WRITE_CYCLES cycles.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      BUSY_IDLE: begin
        if (start) begin
          w_state_next = BUSY_ACTIVE;
          w_cnt_next   = LOAD;
        end
      end
      BUSY_ACTIVE: begin
        if (r_cnt == '0) begin
          w_state_next = BUSY_IDLE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_next = BUSY_IDLE;
    endcase
  end

  assign ready = (r_state == BUSY_IDLE);

endmodule

// File: rtl/psg_write_decoder.sv
// psg_write_decoder: host-side register interface of the SN76489 PSG.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   data[7:0]           host write byte
//   cs_n, we_n          active-low chip select / write enable
//   ready               high = a write can be accepted
//   tone0..tone2        tone period registers (TONE_BITS wide)
//   atten0..atten3      attenuation registers, atten3 = noise channel
//   noise_control[2:0]  {FB, NF1, NF0}
//   restart_noise       one-cycle pulse on every noise register write
//
// Handshake: a write is the rising edge of req = !cs_n & !we_n, sampled at a
// clock edge while ready is high. Edges seen while ready is low are dropped,
// and a held req never repeats. The accepted byte is applied one edge later,
// at which point ready drops for WRITE_CYCLES cycles.
module psg_write_decoder
  import psg_write_decoder_pkg::*;
#(
  parameter int WRITE_CYCLES = 32,
  parameter int TONE_BITS    = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           data,
  input  logic                 cs_n,
  input  logic                 we_n,
  output logic                 ready,
  output logic [TONE_BITS-1:0] tone0,
  output logic [TONE_BITS-1:0] tone1,
  output logic [TONE_BITS-1:0] tone2,
  output logic [3:0]           atten0,
  output logic [3:0]           atten1,
  output logic [3:0]           atten2,
  output logic [3:0]           atten3,
  output logic [2:0]           noise_control,
  output logic                 restart_noise
);

  logic                 w_req;
  logic                 w_ready;
  logic                 w_is_latch;
  logic [2:0]           w_sel;
  logic [1:0]           w_ch;
  reg_type_e            w_type;

  logic                 r_req_d;
  logic                 r_accept;
  logic [7:0]           r_data;
  logic [2:0]           r_latch;
  logic [TONE_BITS-1:0] r_tone [3];
  logic [3:0]           r_atten [4];
  logic [2:0]           r_noise;
  logic                 r_restart;

  assign w_req = ~cs_n & ~we_n;

  // Decode of the byte captured with the accept; a latch byte selects its
  // own target, a data byte reuses the stored latch.
  assign w_is_latch = r_data[7];
  assign w_sel      = w_is_latch ? r_data[6:4] : r_latch;
  assign w_ch       = w_sel[2:1];
  assign w_type     = reg_type_e'(w_sel[0]);

  write_busy_timer #(
    .WRITE_CYCLES(WRITE_CYCLES)
  ) u_busy_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(r_accept),
    .ready(w_ready)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // req history resets high so a request held through reset is not an edge
      r_req_d   <= 1'b1;
      r_accept  <= 1'b0;
      r_data    <= '0;
      r_latch   <= 3'b000;
      r_noise   <= '0;
      r_restart <= 1'b0;
      for (int i = 0; i < 3; i++) r_tone[i] <= '0;
      for (int i = 0; i < 4; i++) r_atten[i] <= ATTEN_RESET;
    end else begin
      r_req_d   <= w_req;
      r_accept  <= w_req & ~r_req_d & w_ready;
      r_data    <= data;
      r_restart <= 1'b0;
      if (r_accept) begin
        if (w_is_latch) r_latch <= r_data[6:4];
        if (w_type == REG_ATTEN) begin
          r_atten[w_ch] <= r_data[3:0];
        end else if (w_ch == NOISE_CHANNEL) begin
          r_noise   <= r_data[2:0];
          r_restart <= 1'b1;
        end else begin
          // Byte-granular tone update: latch byte fills the low nibble,
          // data byte fills the upper bits.
          for (int i = 0; i < 3; i++) begin
            if (w_ch == 2'(i)) begin
              if (w_is_latch) r_tone[i][3:0] <= r_data[3:0];
              else            r_tone[i][TONE_BITS-1:4] <= r_data[TONE_BITS-5:0];
            end
          end
        end
      end
    end
  end

  assign ready         = w_ready;
  assign tone0         = r_tone[0];
  assign tone1         = r_tone[1];
  assign tone2         = r_tone[2];
  assign atten0        = r_atten[0];
  assign atten1        = r_atten[1];
  assign atten2        = r_atten[2];
  assign atten3        = r_atten[3];
  assign noise_control = r_noise;
  assign restart_noise = r_restart;

endmodule

// File: tb/tb_psg_write_decoder.sv
// Testbench for psg_write_decoder: directed table, corner sequences and
// random writes checked against a transaction-level register model.
module tb_psg_write_decoder;

  localparam int WC = 32;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       cs_n;
  logic       we_n;
  logic       ready;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] atten0, atten1, atten2, atten3;
  logic [2:0] noise_control;
  logic       restart_noise;

  psg_write_decoder #(
    .WRITE_CYCLES(WC),
    .TONE_BITS   (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (data),
    .cs_n         (cs_n),
    .we_n         (we_n),
    .ready        (ready),
    .tone0        (tone0),
    .tone1        (tone1),
    .tone2        (tone2),
    .atten0       (atten0),
    .atten1       (atten1),
    .atten2       (atten2),
    .atten3       (atten3),
    .noise_control(noise_control),
    .restart_noise(restart_noise)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];   // expected noise_control value for each restart pulse

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every restart pulse cycle must match one queued noise write.
  always @(negedge clk) begin : restart_monitor
    logic [2:0] e;
    if (restart_noise === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL restart_pulse: got unexpected pulse expected none");
      end else begin
        e = exp_q.pop_front();
        check("restart_noise_value", 32'(noise_control), 32'(e));
      end
    end
  end

  // ---------------- reference model ----------------
  logic [9:0] m_tone [3];
  logic [3:0] m_atten [4];
  logic [2:0] m_noise;
  logic [2:0] m_latch;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_tone[i] = 10'h000;
    for (int i = 0; i < 4; i++) m_atten[i] = 4'hF;
    m_noise = 3'b000;
    m_latch = 3'b000;
  endtask

  // Applies one host byte to the register model; returns 1 for a noise write.
  function automatic bit model_write(input logic [7:0] b);
    int idx;
    bit is_att;
    bit noise;
    noise = 1'b0;
    if (b[7]) m_latch = b[6:4];
    idx    = int'(m_latch[2:1]);
    is_att = m_latch[0];
    if (is_att) begin
      m_atten[idx] = b[3:0];
    end else if (idx == 3) begin
      m_noise = b[2:0];
      noise   = 1'b1;
    end else if (b[7]) begin
      m_tone[idx] = (m_tone[idx] & 10'h3F0) | 10'(b[3:0]);
    end else begin
      m_tone[idx] = (m_tone[idx] & 10'h00F) | (10'(b[5:0]) << 4);
    end
    return noise;
  endfunction

  task automatic check_all(input string name);
    check({name, " tone0"},  32'(tone0),  32'(m_tone[0]));
    check({name, " tone1"},  32'(tone1),  32'(m_tone[1]));
    check({name, " tone2"},  32'(tone2),  32'(m_tone[2]));
    check({name, " atten0"}, 32'(atten0), 32'(m_atten[0]));
    check({name, " atten1"}, 32'(atten1), 32'(m_atten[1]));
    check({name, " atten2"}, 32'(atten2), 32'(m_atten[2]));
    check({name, " atten3"}, 32'(atten3), 32'(m_atten[3]));
    check({name, " noise"},  32'(noise_control), 32'(m_noise));
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string name);
    int g;
    g = 0;
    while (ready !== 1'b1 && g < 64) begin
      @(negedge clk);
      g++;
    end
    check({name, " ready before write"}, 32'(ready), 32'd1);
  endtask

  // Issues one write starting at a negedge; returns at the negedge after
  // the apply edge, having checked registers, pulse and ready there.
  task automatic do_write(input logic [7:0] b, input string name, input bit hold);
    bit nz;
    wait_ready(name);
    data = b;
    cs_n = 1'b0;
    we_n = 1'b0;
    nz   = model_write(b);
    if (nz) exp_q.push_back(m_noise);
    @(negedge clk);
    if (!hold) begin
      cs_n = 1'b1;
      we_n = 1'b1;
    end
    @(negedge clk);
    check_all(name);
    check({name, " restart"}, 32'(restart_noise), 32'(nz));
    check({name, " ready low"}, 32'(ready), 32'd0);
  endtask

  // Counts ready-low cycles starting with the current one.
  task automatic wait_idle(input string name, input int expected);
    int lowcnt;
    lowcnt = 0;
    while (ready === 1'b0 && lowcnt < 200) begin
      lowcnt++;
      @(negedge clk);
    end
    check({name, " busy length"}, 32'(lowcnt), 32'(expected));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] din;
    logic [9:0] e_tone0;
    logic [3:0] e_atten0;
    logic [3:0] e_atten1;
    logic [2:0] e_noise;
    bit         e_restart;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h8E, 10'h00E, 4'hF, 4'hF, 3'b000, 1'b0};
    vecs[1] = '{8'h0F, 10'h0FE, 4'hF, 4'hF, 3'b000, 1'b0};
    vecs[2] = '{8'hE5, 10'h0FE, 4'hF, 4'hF, 3'b101, 1'b1};
    vecs[3] = '{8'h06, 10'h0FE, 4'hF, 4'hF, 3'b110, 1'b1};
    vecs[4] = '{8'hBF, 10'h0FE, 4'hF, 4'hF, 3'b110, 1'b0};
    vecs[5] = '{8'h93, 10'h0FE, 4'h3, 4'hF, 3'b110, 1'b0};

    // Reset with the request already asserted: no write may follow.
    rst_n = 1'b0;
    cs_n  = 1'b0;
    we_n  = 1'b0;
    data  = 8'h8F;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_all("reset");
    check("reset ready", 32'(ready), 32'd1);
    check("reset restart", 32'(restart_noise), 32'd0);
    cs_n = 1'b1;
    we_n = 1'b1;
    @(negedge clk);

    // Table-driven directed writes.
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].din, $sformatf("vec%0d", i), 1'b0);
      check($sformatf("vec%0d tbl tone0", i),  32'(tone0),  32'(vecs[i].e_tone0));
      check($sformatf("vec%0d tbl atten0", i), 32'(atten0), 32'(vecs[i].e_atten0));
      check($sformatf("vec%0d tbl atten1", i), 32'(atten1), 32'(vecs[i].e_atten1));
      check($sformatf("vec%0d tbl noise", i),  32'(noise_control), 32'(vecs[i].e_noise));
      check($sformatf("vec%0d tbl restart", i), 32'(restart_noise), 32'(vecs[i].e_restart));
      wait_idle($sformatf("vec%0d", i), WC);
    end

    // A fresh request edge during BUSY is dropped.
    do_write(8'hA2, "busy_edge", 1'b0);
    @(negedge clk);
    data = 8'h84;
    cs_n = 1'b0;
    we_n = 1'b0;
    @(negedge clk);
    cs_n = 1'b1;
    we_n = 1'b1;
    @(negedge clk);
    check_all("busy_edge ignored");
    wait_idle("busy_edge", WC - 3);
    repeat (2) @(negedge clk);
    check_all("busy_edge after idle");

    // Request held asserted across BUSY->IDLE: no second write.
    do_write(8'h23, "hold", 1'b1);
    data = 8'h81;
    wait_idle("hold", WC);
    repeat (4) @(negedge clk);
    check_all("hold no rewrite");
    check("hold ready", 32'(ready), 32'd1);
    cs_n = 1'b1;
    we_n = 1'b1;
    @(negedge clk);

    // Random writes, some issued in the same cycle ready rises.
    repeat (120) begin
      do_write(8'($urandom_range(0, 255)), "rand", 1'b0);
      wait_idle("rand", WC);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the 10th BUSY cycle.
    do_write(8'hC7, "mid_reset", 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    check_all("mid_reset");
    check("mid_reset ready", 32'(ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Data byte after reset goes to tone0 upper bits via the reset latch.
    do_write(8'h05, "post_reset", 1'b0);
    check("post_reset tone0", 32'(tone0), 32'h050);
    wait_idle("post_reset", WC);

    @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psg_write_decoder.md
# psg_write_decoder

Bus-side register interface of the SN76489 PSG: accepts 8-bit latch/data byte writes from the host pins, maintains the latched-register pointer and all channel registers, and drives the tone period, attenuation and noise control buses consumed by the tone, noise and attenuation blocks. It produces the one-cycle `restart_noise` pulse that resets the noise LFSR and a READY handshake that holds the host off while a write is absorbed.

## Interface
- `WRITE_CYCLES`, 32: cycles READY stays low after an accepted write.
- `TONE_BITS`, 10: tone period width.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `data`  in  8  host write byte.
- `cs_n`  in  1  chip select, active-low.
- `we_n`  in  1  write enable, active-low.
- `ready`  out  1  high = idle, write can be accepted.
- `tone0`, `tone1`, `tone2`  out  10 each  tone period registers.
- `atten0`..`atten3`  out  4 each  attenuation; index 3 = noise channel.
- `noise_control`  out  3  {FB, NF1, NF0}.
- `restart_noise`  out  1  one-cycle pulse on any noise register write.

## Operation
- Write request `req = !cs_n & !we_n`. Accept on the first cycle `req` is high after being low (rising edge of `req`) while `ready`=1. Requests while `ready`=0 are dropped. Holding `req` does not repeat the write.
- Byte decoding:
  - Latch byte (`data[7]`=1): latch ← `data[6:4]` (channel = `[6:5]`, type = `[4]`, 1 = attenuation). Write `data[3:0]` into the selected register: tone → bits 3:0, attenuation → all 4 bits, noise → `noise_control` ← `data[2:0]`.
  - Data byte (`data[7]`=0): use the stored latch. Tone → bits 9:4 ← `data[5:0]`. Attenuation → ← `data[3:0]`. Noise → `noise_control` ← `data[2:0]`.
- Channel 3 with type 0 selects the noise register. Channel 3 with type 1 selects `atten3`.
- `restart_noise` pulses for every accepted noise-register write, including rewriting the same value.
- Busy FSM:
  - IDLE (`ready`=1) → BUSY on accept. The counter loads `WRITE_CYCLES-1`.
  - BUSY decrements the counter and returns to IDLE when it reaches 0.
  - With `WRITE_CYCLES`=1, BUSY lasts one cycle.
- Reset values:
  - `tone0..2` = 0.
  - `atten0..3` = 4'hF (silent).
  - `noise_control` = 0.
  - latch = 3'b000 (tone0).
  - `restart_noise` = 0, `ready` = 1, FSM in IDLE.
  - The `req` history register resets to 1, so a request already held low through reset is not accepted.
- Reset mid-BUSY: returns to IDLE immediately. Register contents return to reset values.

## Timing
- All outputs are registered.
- A write accepted at edge N:
  - updates the registers visible after edge N+1;
  - `restart_noise` is high for the cycle after edge N+1;
  - `ready` falls after edge N+1 and stays low for exactly `WRITE_CYCLES` cycles.
- A request edge in the same cycle `ready` rises is accepted.
- Tone writes are byte-granular. The partial value is visible between the latch byte and the data byte; no double-buffering.

## Structure
- Shared package holds:
  - type encodings `REG_TONE`=0, `REG_ATTEN`=1;
  - `NOISE_CHANNEL`=2'd3;
  - attenuation reset constant 4'hF.
- One natural sub-module, `write_busy_timer`: the `WRITE_CYCLES` down-counter and IDLE/BUSY FSM, with input `start` and output `ready`.
- Byte decode and the register file stay in the top module.

## Test plan
- After reset: `ready`=1, all tones 0, all attenuations F, `noise_control`=0. Hold `req` low through the reset release → no write occurs.
- Write 0x8E then 0x0F (tone0, `WRITE_CYCLES`=32) → `tone0`=10'h0FE.
  - After the first byte: `tone0`=0x00E, `ready` low for exactly 32 cycles.
- Write 0xE5 → `noise_control`=3'b101 and one `restart_noise` pulse. Then data byte 0x06 → `noise_control`=3'b110 and a second pulse.
- Write 0xBF (atten1 = F), then 0x93 → `atten0`=3. Tone registers are unchanged.
- Issue a second request edge during BUSY → it is ignored with no register change.
  - Hold `req` low across the BUSY→IDLE transition with no new edge → no write.
- Assert `rst_n`=0 at cycle 10 of BUSY → next cycle `ready`=1 and all registers are at reset values.
